// File: rtl/dcache_wbuf.sv
// Posted write buffer between the dcache write port and the AXI master write port.
// Optional write merging into the youngest entry is enabled by defining DCACHE_WBUF_MERGE_EN.
`ifndef CACHE_BLK_SIZE
`define CACHE_BLK_SIZE 128
`endif

module dcache_wbuf #(
    parameter int DEPTH         = 4,
    parameter int LINE_OFFSET_W = 4,
    parameter int BLK_W         = `CACHE_BLK_SIZE
) (
    input  logic             cpu_clk,
    input  logic             cpu_rstn,
    output logic             dc_wrdy,
    input  logic [3:0]       dc_wen,
    input  logic [31:0]      dc_waddr,
    input  logic [31:0]      dc_wdata,
    output logic             dc_rrdy,
    input  logic [3:0]       dc_ren,
    input  logic [31:0]      dc_raddr,
    output logic             dc_rvalid,
    output logic [BLK_W-1:0] dc_rdata,
    input  logic             bus_wrdy,
    output logic [3:0]       bus_wen,
    output logic [31:0]      bus_waddr,
    output logic [31:0]      bus_wdata,
    input  logic             bus_rrdy,
    output logic [3:0]       bus_ren,
    output logic [31:0]      bus_raddr,
    input  logic             bus_rvalid,
    input  logic [BLK_W-1:0] bus_rdata,
    output logic             wbuf_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [3:0]       ent_wen  [DEPTH];
    logic [31:0]      ent_addr [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             merge;
    logic             alloc;
    logic             hit;

    assign dc_wrdy    = (count != FULL);
    assign wbuf_empty = (count == '0);
    assign push       = (|dc_wen) && dc_wrdy;
    assign pop        = (|bus_wen) && bus_wrdy;
    assign alloc      = push && !merge;

`ifdef DCACHE_WBUF_MERGE_EN
    logic [PTR_W-1:0] tail_prev;
    assign tail_prev = tail - PTR_W'(1);
    // Youngest entry is only mergeable when it is not the head, so the head stays stable.
    assign merge = push && (count >= CNT_W'(2)) &&
                   (ent_addr[tail_prev][31:2] == dc_waddr[31:2]);
`else
    assign merge = 1'b0;
`endif

    assign bus_wen   = wbuf_empty ? 4'b0000 : ent_wen[head];
    assign bus_waddr = ent_addr[head];
    assign bus_wdata = ent_data[head];

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (ent_addr[i][31:LINE_OFFSET_W] == dc_raddr[31:LINE_OFFSET_W]))
                hit = 1'b1;
        end
        hit = hit && (|dc_ren);
    end

    assign bus_ren   = hit ? 4'b0000 : dc_ren;
    assign bus_raddr = dc_raddr;
    assign dc_rrdy   = bus_rrdy && !hit;
    assign dc_rvalid = bus_rvalid;
    assign dc_rdata  = bus_rdata;

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (alloc) begin
                tail        <= tail + PTR_W'(1);
                valid[tail] <= 1'b1;
            end
            if (pop) begin
                head        <= head + PTR_W'(1);
                valid[head] <= 1'b0;
            end
            case ({alloc, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: valid/count gate every use of it.
    always_ff @(posedge cpu_clk) begin
        if (alloc) begin
            ent_wen[tail]  <= dc_wen;
            ent_addr[tail] <= dc_waddr;
            ent_data[tail] <= dc_wdata;
        end
`ifdef DCACHE_WBUF_MERGE_EN
        else if (merge) begin
            for (int b = 0; b < 4; b++) begin
                if (dc_wen[b]) begin
                    ent_data[tail_prev][8*b +: 8] <= dc_wdata[8*b +: 8];
                    ent_wen[tail_prev][b]         <= 1'b1;
                end
            end
        end
`endif
    end

endmodule

// File: tb/tb_dcache_wbuf.sv
// Directed self-checking bench for dcache_wbuf; merge scenario runs only with DCACHE_WBUF_MERGE_EN.
module tb_dcache_wbuf;

    localparam int BLK_W = 128;

    logic             cpu_clk;
    logic             cpu_rstn;
    logic             dc_wrdy;
    logic [3:0]       dc_wen;
    logic [31:0]      dc_waddr;
    logic [31:0]      dc_wdata;
    logic             dc_rrdy;
    logic [3:0]       dc_ren;
    logic [31:0]      dc_raddr;
    logic             dc_rvalid;
    logic [BLK_W-1:0] dc_rdata;
    logic             bus_wrdy;
    logic [3:0]       bus_wen;
    logic [31:0]      bus_waddr;
    logic [31:0]      bus_wdata;
    logic             bus_rrdy;
    logic [3:0]       bus_ren;
    logic [31:0]      bus_raddr;
    logic             bus_rvalid;
    logic [BLK_W-1:0] bus_rdata;
    logic             wbuf_empty;

    int total_cnt = 0;
    int pass_cnt  = 0;

    dcache_wbuf #(.DEPTH(4), .LINE_OFFSET_W(4), .BLK_W(BLK_W)) dut (
        .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
        .dc_wrdy(dc_wrdy), .dc_wen(dc_wen), .dc_waddr(dc_waddr), .dc_wdata(dc_wdata),
        .dc_rrdy(dc_rrdy), .dc_ren(dc_ren), .dc_raddr(dc_raddr),
        .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
        .bus_wrdy(bus_wrdy), .bus_wen(bus_wen), .bus_waddr(bus_waddr), .bus_wdata(bus_wdata),
        .bus_rrdy(bus_rrdy), .bus_ren(bus_ren), .bus_raddr(bus_raddr),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .wbuf_empty(wbuf_empty)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic test_reset();
        cpu_rstn = 1'b0;
        #3;
        total_cnt++;
        if (bus_wen !== 4'h0) $display("[TB] FAIL reset_bus_wen: got %h expected 0", bus_wen);
        else pass_cnt++;
        total_cnt++;
        if (wbuf_empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b expected 1", wbuf_empty);
        else pass_cnt++;
        total_cnt++;
        if (dc_wrdy !== 1'b1) $display("[TB] FAIL reset_wrdy: got %b expected 1", dc_wrdy);
        else pass_cnt++;
        tick();
        cpu_rstn = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        bus_wrdy = 1'b1;
        dc_wen = 4'hF; dc_waddr = 32'h1C00_0010; dc_wdata = 32'hDEAD_BEEF;
        tick();
        dc_wen = 4'h0;
        total_cnt++;
        if (bus_wen !== 4'hF) $display("[TB] FAIL single_wen: got %h expected f", bus_wen);
        else pass_cnt++;
        total_cnt++;
        if (bus_waddr !== 32'h1C00_0010) $display("[TB] FAIL single_addr: got %h expected 1c000010", bus_waddr);
        else pass_cnt++;
        total_cnt++;
        if (bus_wdata !== 32'hDEAD_BEEF) $display("[TB] FAIL single_data: got %h expected deadbeef", bus_wdata);
        else pass_cnt++;
        total_cnt++;
        if (wbuf_empty !== 1'b0) $display("[TB] FAIL single_notempty: got %b expected 0", wbuf_empty);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (wbuf_empty !== 1'b1) $display("[TB] FAIL single_empty_after: got %b expected 1", wbuf_empty);
        else pass_cnt++;
        total_cnt++;
        if (bus_wen !== 4'h0) $display("[TB] FAIL single_wen_after: got %h expected 0", bus_wen);
        else pass_cnt++;
    endtask

    task automatic test_full();
        bus_wrdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dc_wen = 4'hF; dc_waddr = 32'h1000_0000 + 32'(i * 'h40); dc_wdata = 32'h100 + 32'(i);
            tick();
        end
        total_cnt++;
        if (dc_wrdy !== 1'b0) $display("[TB] FAIL full_wrdy: got %b expected 0", dc_wrdy);
        else pass_cnt++;
        dc_waddr = 32'h1000_0BAD; dc_wdata = 32'h0000_0BAD;
        tick();
        dc_wen = 4'h0;
        total_cnt++;
        if (dc_wrdy !== 1'b0) $display("[TB] FAIL full_wrdy_5th: got %b expected 0", dc_wrdy);
        else pass_cnt++;
        bus_wrdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (bus_waddr !== 32'h1000_0000 + 32'(i * 'h40))
                $display("[TB] FAIL drain_addr%0d: got %h expected %h", i, bus_waddr, 32'h1000_0000 + 32'(i * 'h40));
            else pass_cnt++;
            total_cnt++;
            if (bus_wdata !== 32'h100 + 32'(i))
                $display("[TB] FAIL drain_data%0d: got %h expected %h", i, bus_wdata, 32'h100 + 32'(i));
            else pass_cnt++;
            tick();
            if (i == 0) begin
                total_cnt++;
                if (dc_wrdy !== 1'b1) $display("[TB] FAIL wrdy_after_pop: got %b expected 1", dc_wrdy);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (bus_wen !== 4'h0) $display("[TB] FAIL no_fifth_write: got %h expected 0", bus_wen);
        else pass_cnt++;
        total_cnt++;
        if (wbuf_empty !== 1'b1) $display("[TB] FAIL full_drained: got %b expected 1", wbuf_empty);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bus_wrdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dc_wen = 4'h3; dc_waddr = 32'h2000_0000 + 32'(i * 4); dc_wdata = 32'hA0 + 32'(i);
            tick();
            total_cnt++;
            if (bus_waddr !== 32'h2000_0000 + 32'(i * 4) || bus_wen !== 4'h3)
                $display("[TB] FAIL b2b_head%0d: got %h/%h expected %h/3", i, bus_waddr, bus_wen, 32'h2000_0000 + 32'(i * 4));
            else pass_cnt++;
        end
        dc_wen = 4'h0;
        total_cnt++;
        if (wbuf_empty !== 1'b0) $display("[TB] FAIL b2b_count1: got %b expected 0", wbuf_empty);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (wbuf_empty !== 1'b1) $display("[TB] FAIL b2b_drained: got %b expected 1", wbuf_empty);
        else pass_cnt++;
    endtask

    task automatic test_read_hazard();
        bus_wrdy = 1'b0; bus_rrdy = 1'b1;
        dc_wen = 4'hF; dc_waddr = 32'h1C00_0104; dc_wdata = 32'h55;
        tick();
        dc_wen = 4'h0;
        dc_ren = 4'hF; dc_raddr = 32'h1C00_0100;
        #1;
        total_cnt++;
        if (bus_ren !== 4'h0) $display("[TB] FAIL hazard_ren: got %h expected 0", bus_ren);
        else pass_cnt++;
        total_cnt++;
        if (dc_rrdy !== 1'b0) $display("[TB] FAIL hazard_rrdy: got %b expected 0", dc_rrdy);
        else pass_cnt++;
        total_cnt++;
        if (bus_raddr !== 32'h1C00_0100) $display("[TB] FAIL hazard_raddr: got %h expected 1c000100", bus_raddr);
        else pass_cnt++;
        dc_raddr = 32'h1C00_010F;
        tick();
        total_cnt++;
        if (bus_ren !== 4'h0) $display("[TB] FAIL hazard_line_end: got %h expected 0", bus_ren);
        else pass_cnt++;
        bus_wrdy = 1'b1;
        tick();
        total_cnt++;
        if (bus_ren !== 4'hF) $display("[TB] FAIL hazard_cleared_ren: got %h expected f", bus_ren);
        else pass_cnt++;
        total_cnt++;
        if (dc_rrdy !== 1'b1) $display("[TB] FAIL hazard_cleared_rrdy: got %b expected 1", dc_rrdy);
        else pass_cnt++;
        dc_ren = 4'h0;
    endtask

    task automatic test_read_pass();
        bus_wrdy = 1'b0; bus_rrdy = 1'b0;
        dc_wen = 4'hF; dc_waddr = 32'h1C00_0104; dc_wdata = 32'h66;
        tick();
        dc_wen = 4'h0;
        dc_ren = 4'hF; dc_raddr = 32'h1C00_0200;
        #1;
        total_cnt++;
        if (bus_ren !== 4'hF) $display("[TB] FAIL pass_ren: got %h expected f", bus_ren);
        else pass_cnt++;
        total_cnt++;
        if (dc_rrdy !== 1'b0) $display("[TB] FAIL pass_rrdy_low: got %b expected 0", dc_rrdy);
        else pass_cnt++;
        bus_rrdy = 1'b1; dc_raddr = 32'h1C00_0110;
        #1;
        total_cnt++;
        if (dc_rrdy !== 1'b1 || bus_ren !== 4'hF)
            $display("[TB] FAIL pass_next_line: got %b/%h expected 1/f", dc_rrdy, bus_ren);
        else pass_cnt++;
        bus_rvalid = 1'b1; bus_rdata = {32'h0123_4567, 32'h89AB_CDEF, 32'hCAFE_F00D, 32'h1234_5678};
        #1;
        total_cnt++;
        if (dc_rvalid !== 1'b1 || dc_rdata !== {32'h0123_4567, 32'h89AB_CDEF, 32'hCAFE_F00D, 32'h1234_5678})
            $display("[TB] FAIL refill_pass: got %b/%h expected 1/0123456789abcdefcafef00d12345678", dc_rvalid, dc_rdata);
        else pass_cnt++;
        bus_rvalid = 1'b0; dc_ren = 4'h0;
        bus_wrdy = 1'b1;
        tick();
    endtask

`ifdef DCACHE_WBUF_MERGE_EN
    task automatic test_merge();
        bus_wrdy = 1'b0;
        dc_wen = 4'h1; dc_waddr = 32'h100; dc_wdata = 32'h11;
        tick();
        dc_wen = 4'h1; dc_waddr = 32'h200; dc_wdata = 32'hAA;
        tick();
        dc_wen = 4'h2; dc_waddr = 32'h200; dc_wdata = 32'hBB00;
        tick();
        dc_wen = 4'h0;
        bus_wrdy = 1'b1;
        total_cnt++;
        if (bus_waddr !== 32'h100 || bus_wen !== 4'h1)
            $display("[TB] FAIL merge_head: got %h/%h expected 100/1", bus_waddr, bus_wen);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus_waddr !== 32'h200 || bus_wen !== 4'h3 || bus_wdata !== 32'hBBAA)
            $display("[TB] FAIL merge_entry: got %h/%h/%h expected 200/3/bbaa", bus_waddr, bus_wen, bus_wdata);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (wbuf_empty !== 1'b1) $display("[TB] FAIL merge_count: got %b expected 1", wbuf_empty);
        else pass_cnt++;
    endtask
`endif

    task automatic test_async_reset();
        bus_wrdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dc_wen = 4'hF; dc_waddr = 32'h3000_0000 + 32'(i * 'h10); dc_wdata = 32'(i);
            tick();
        end
        dc_wen = 4'h0;
        bus_wrdy = 1'b1;
        tick();
        #2;
        cpu_rstn = 1'b0;
        #1;
        total_cnt++;
        if (bus_wen !== 4'h0) $display("[TB] FAIL arst_wen: got %h expected 0", bus_wen);
        else pass_cnt++;
        total_cnt++;
        if (wbuf_empty !== 1'b1) $display("[TB] FAIL arst_empty: got %b expected 1", wbuf_empty);
        else pass_cnt++;
        total_cnt++;
        if (dc_wrdy !== 1'b1) $display("[TB] FAIL arst_wrdy: got %b expected 1", dc_wrdy);
        else pass_cnt++;
        tick();
        #2;
        cpu_rstn = 1'b1;
        tick();
        tick();
        total_cnt++;
        if (bus_wen !== 4'h0 || wbuf_empty !== 1'b1)
            $display("[TB] FAIL arst_no_stale: got %h/%b expected 0/1", bus_wen, wbuf_empty);
        else pass_cnt++;
    endtask

    initial begin
        cpu_rstn = 1'b0;
        dc_wen = 4'h0; dc_waddr = '0; dc_wdata = '0;
        dc_ren = 4'h0; dc_raddr = '0;
        bus_wrdy = 1'b0; bus_rrdy = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        test_reset();
        test_single_write();
        test_full();
        test_back_to_back();
        test_read_hazard();
        test_read_pass();
`ifdef DCACHE_WBUF_MERGE_EN
        test_merge();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
